// File: rtl/rv_mem_resp.sv
// rv_mem_resp: slave memory responder for the multicycle RISC-V core (fetch/load/store on one word array).
// Latency: WAIT_CYCLES+1 cycles from the acceptance edge to the one-cycle ready pulse.
// Backpressure: one transaction at a time; req is only sampled in IDLE, so the requester holds until ready.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req, we       request valid; 1 = store, 0 = fetch/load
//   addr, wdata   byte address and store data (latched at acceptance)
//   rdata         read data, updated only by read accesses, valid while ready=1
//   ready         one-cycle completion pulse
//   err           misaligned-access flag alongside ready (only with RV_MEM_MISALIGN_ERR_EN)
//
// Optional build macro RV_MEM_MISALIGN_ERR_EN: flag misaligned accesses, suppress misaligned
// writes and return zero for misaligned reads. Undefined: addr[1:0] ignored, err tied low.
module rv_mem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int         ADDR_W    = $clog2(DEPTH_WORDS);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [29:0] r_waddr;      // word address; byte offset kept separately when it matters
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_access;
    logic        w_ready;
    logic        w_acc_we;
    logic [29:0] w_acc_waddr;
    logic [31:0] w_acc_wdata;
    logic        w_acc_mis;
    logic        w_oor;
    logic [ADDR_W-1:0] w_idx;

    // Next state and strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    if (ZERO_WAIT) begin
                        w_access    = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_ready     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // With zero wait states the access happens on the acceptance edge itself, so the
    // live inputs are used there; every later access uses the latched copy.
    always_comb begin
        w_acc_we    = (r_state == IDLE) ? we          : r_we;
        w_acc_waddr = (r_state == IDLE) ? addr[31:2]  : r_waddr;
        w_acc_wdata = (r_state == IDLE) ? wdata       : r_wdata;
    end

`ifdef RV_MEM_MISALIGN_ERR_EN
    logic r_mis;
    assign w_acc_mis = (r_state == IDLE) ? (addr[1:0] != 2'b00) : r_mis;
    assign err       = w_ready & r_mis;
`else
    logic w_unused;
    assign w_unused  = ^addr[1:0];
    assign w_acc_mis = 1'b0;
    assign err       = 1'b0;
`endif

    assign w_oor = |w_acc_waddr[29:ADDR_W];
    assign w_idx = w_acc_waddr[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_waddr <= 30'd0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
`ifdef RV_MEM_MISALIGN_ERR_EN
            r_mis   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= we;
                r_waddr <= addr[31:2];
                r_wdata <= wdata;
                r_cnt   <= CNT_INIT;
`ifdef RV_MEM_MISALIGN_ERR_EN
                r_mis   <= (addr[1:0] != 2'b00);
`endif
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !w_acc_we) begin
                r_rdata <= (w_oor || w_acc_mis) ? 32'h0 : r_mem[w_idx];
            end
        end
    end

    // Storage has no reset; a write landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_access && w_acc_we && !w_oor && !w_acc_mis) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

    assign rdata = r_rdata;
    assign ready = w_ready;

endmodule

// File: tb/tb_rv_mem_resp.sv
module tb_rv_mem_resp;

    localparam int DEPTH0 = 1024;
    localparam int WAIT0  = 2;
    localparam int DEPTH1 = 16;
    localparam int WAIT1  = 0;
`ifdef RV_MEM_MISALIGN_ERR_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, we0, ready0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, ready1, err1;
    logic [31:0] addr1, wdata1, rdata1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rv_mem_resp #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(WAIT0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .err(err0));

    rv_mem_resp #(.DEPTH_WORDS(DEPTH1), .WAIT_CYCLES(WAIT1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .ready(ready1), .err(err1));

    // Reference model of dut0: sparse word store plus the last value returned by a read.
    logic [31:0] mem_m [int];
    logic [31:0] last_rd    = 32'h0;
    bit          last_known = 1'b1;

    function automatic void model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                                      output logic [31:0] exp_rd, output logic exp_err,
                                      output bit known);
        bit oor;
        bit mis;
        int idx;
        oor = (a >= 32'(DEPTH0 * 4));
        mis = MIS_EN && ((a % 4) != 0);
        idx = int'((a % 32'(DEPTH0 * 4)) / 4);
        exp_err = mis;
        if (w) begin
            if (!oor && !mis) mem_m[idx] = d;
        end else if (oor || mis) begin
            last_rd = 32'h0; last_known = 1'b1;
        end else if (mem_m.exists(idx)) begin
            last_rd = mem_m[idx]; last_known = 1'b1;
        end else begin
            last_known = 1'b0;
        end
        exp_rd = last_rd;
        known  = last_known;
    endfunction

    // Issue one request starting at a negedge with the DUT idle; ends at the negedge one
    // cycle after ready. Inputs are scrambled right after acceptance to prove latching.
    task automatic txn(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat,
                       output int rcyc, output logic rdy_after);
        logic r;
        rd = 32'h0; e = 1'b0; lat = -1; rcyc = -1;
        if (!sel) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else      begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!sel) begin we0 = ~w; addr0 = $urandom; wdata0 = $urandom; end
                else      begin we1 = ~w; addr1 = $urandom; wdata1 = $urandom; end
            end
            r = sel ? ready1 : ready0;
            if (r === 1'b1) begin
                lat  = c;
                rcyc = cyc;
                rd   = sel ? rdata1 : rdata0;
                e    = sel ? err1 : err0;
                break;
            end
        end
        if (!sel) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        rdy_after = sel ? ready1 : ready0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", ready0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0: got %b want 0", err0); end
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", ready1); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL idle_ready0: got %b want 0", ready0); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd, xr; logic e, xe, ra; int lat, rc; bit kn;
        model_txn(1'b1, 32'h10, 32'hDEADBEEF, xr, xe, kn);
        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat, rc, ra);
        checks++; if (lat != WAIT0 + 1) begin errors++; $display("FAIL wr_latency: got %0d want %0d", lat, WAIT0 + 1); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL wr_pulse_width: ready after pulse %b want 0", ra); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", e); end
        model_txn(1'b0, 32'h10, 32'h0, xr, xe, kn);
        txn(1'b0, 1'b0, 32'h10, 32'h0, rd, e, lat, rc, ra);
        checks++; if (lat != WAIT0 + 1) begin errors++; $display("FAIL rd_latency: got %0d want %0d", lat, WAIT0 + 1); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", e); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, xr; logic e, xe, ra; int lat, rc; bit kn;
        model_txn(1'b1, 32'h0, 32'h0BADF00D, xr, xe, kn);
        txn(1'b0, 1'b1, 32'h0, 32'h0BADF00D, rd, e, lat, rc, ra);
        model_txn(1'b1, 32'h0001_0000, 32'hFFFFFFFF, xr, xe, kn);
        txn(1'b0, 1'b1, 32'h0001_0000, 32'hFFFFFFFF, rd, e, lat, rc, ra);
        checks++; if (lat != WAIT0 + 1) begin errors++; $display("FAIL oor_wr_latency: got %0d want %0d", lat, WAIT0 + 1); end
        model_txn(1'b0, 32'h0, 32'h0, xr, xe, kn);
        txn(1'b0, 1'b0, 32'h0, 32'h0, rd, e, lat, rc, ra);
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL oor_no_alias: got %h want 0badf00d", rd); end
        model_txn(1'b0, 32'h0001_0000, 32'h0, xr, xe, kn);
        txn(1'b0, 1'b0, 32'h0001_0000, 32'h0, rd, e, lat, rc, ra);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_zero: got %h want 0", rd); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd, xr; logic e, xe, ra; int lat, rc; bit kn; bit seen;
        for (int d = 1; d <= WAIT0; d++) begin
            model_txn(1'b1, 32'h20, 32'h11111111, xr, xe, kn);
            txn(1'b0, 1'b1, 32'h20, 32'h11111111, rd, e, lat, rc, ra);
            seen = 1'b0;
            req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h12345678;
            @(posedge clk);
            for (int k = 1; k < d; k++) begin
                @(negedge clk);
                seen |= ready0;
            end
            @(negedge clk);
            seen |= ready0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0; req0 = 1'b0;
            checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rstmid_rdata d=%0d: got %h want 0", d, rdata0); end
            for (int k = 0; k < 5; k++) begin
                seen |= ready0;
                @(negedge clk);
            end
            checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_ready d=%0d: ready seen %b want 0", d, seen); end
            last_rd = 32'h0; last_known = 1'b1;
            model_txn(1'b0, 32'h20, 32'h0, xr, xe, kn);
            txn(1'b0, 1'b0, 32'h20, 32'h0, rd, e, lat, rc, ra);
            checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL rstmid_persist d=%0d: got %h want 11111111", d, rd); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, xr; logic e, xe, ra; int lat, rc1, rc2; bit kn;
        model_txn(1'b1, 32'h40, 32'hA5A5A5A5, xr, xe, kn);
        txn(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, rd, e, lat, rc1, ra);
        model_txn(1'b0, 32'h40, 32'h0, xr, xe, kn);
        txn(1'b0, 1'b0, 32'h40, 32'h0, rd, e, lat, rc2, ra);
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_data: got %h want a5a5a5a5", rd); end
        checks++; if (rc2 - rc1 != WAIT0 + 2) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", rc2 - rc1, WAIT0 + 2); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic e, ra; int lat, rc1, rc2;
        txn(1'b1, 1'b1, 32'h8, 32'hCAFEF00D, rd, e, lat, rc1, ra);
        checks++; if (lat != WAIT1 + 1) begin errors++; $display("FAIL zw_wr_latency: got %0d want %0d", lat, WAIT1 + 1); end
        txn(1'b1, 1'b0, 32'h8, 32'h0, rd, e, lat, rc2, ra);
        checks++; if (lat != WAIT1 + 1) begin errors++; $display("FAIL zw_rd_latency: got %0d want %0d", lat, WAIT1 + 1); end
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL zw_rd_data: got %h want cafef00d", rd); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL zw_pulse_width: ready after pulse %b want 0", ra); end
        checks++; if (rc2 - rc1 != WAIT1 + 2) begin errors++; $display("FAIL zw_gap: got %0d want %0d", rc2 - rc1, WAIT1 + 2); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, xr; logic e, xe, ra; int lat, rc; bit kn;
        model_txn(1'b1, 32'h10, 32'h01020304, xr, xe, kn);
        txn(1'b0, 1'b1, 32'h10, 32'h01020304, rd, e, lat, rc, ra);
        model_txn(1'b1, 32'h13, 32'h77777777, xr, xe, kn);
        txn(1'b0, 1'b1, 32'h13, 32'h77777777, rd, e, lat, rc, ra);
        checks++; if (e !== MIS_EN) begin errors++; $display("FAIL mis_wr_err: got %b want %b", e, MIS_EN); end
        checks++; if (lat != WAIT0 + 1) begin errors++; $display("FAIL mis_wr_latency: got %0d want %0d", lat, WAIT0 + 1); end
        model_txn(1'b0, 32'h10, 32'h0, xr, xe, kn);
        txn(1'b0, 1'b0, 32'h10, 32'h0, rd, e, lat, rc, ra);
        checks++; if (rd !== (MIS_EN ? 32'h01020304 : 32'h77777777)) begin
            errors++; $display("FAIL mis_word: got %h want %h", rd, MIS_EN ? 32'h01020304 : 32'h77777777); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL mis_aligned_err: got %b want 0", e); end
        model_txn(1'b0, 32'h12, 32'h0, xr, xe, kn);
        txn(1'b0, 1'b0, 32'h12, 32'h0, rd, e, lat, rc, ra);
        checks++; if (rd !== xr) begin errors++; $display("FAIL mis_rd_data: got %h want %h", rd, xr); end
        checks++; if (e !== xe) begin errors++; $display("FAIL mis_rd_err: got %b want %b", e, xe); end
    endtask

    task automatic test_random();
        logic [31:0] rd, xr, a, d; logic e, xe, ra, w; int lat, rc; bit kn;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model_txn(1'b1, 32'(i * 4), d, xr, xe, kn);
            txn(1'b0, 1'b1, 32'(i * 4), d, rd, e, lat, rc, ra);
        end
        for (int i = 0; i < 48; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'h0010_0000;
            d = $urandom;
            model_txn(w, a, d, xr, xe, kn);
            txn(1'b0, w, a, d, rd, e, lat, rc, ra);
            checks++; if (lat != WAIT0 + 1) begin errors++; $display("FAIL rnd_latency #%0d: got %0d want %0d", i, lat, WAIT0 + 1); end
            if (kn) begin
                checks++; if (rd !== xr) begin errors++; $display("FAIL rnd_rdata #%0d we=%b a=%h: got %h want %h", i, w, a, rd, xr); end
            end
            checks++; if (e !== xe) begin errors++; $display("FAIL rnd_err #%0d a=%h: got %b want %b", i, a, e, xe); end
            checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rnd_pulse_width #%0d: got %b want 0", i, ra); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_reset_mid_write();
        test_back_to_back();
        test_zero_wait();
        test_misaligned();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
